// File: rtl/regfile_pkg.sv
// Shared types, default sizing and helpers for the integer register file with busy scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_REG_NUM     = 32;
   localparam int DEF_REG_NUM_BIT = 5;
   localparam int DEF_RD_PORTS    = 2;
   localparam int DEF_WR_PORTS    = 1;

   typedef logic [DEF_REG_NUM_BIT-1:0] reg_addr_t;
   typedef logic [DEF_DATA_WIDTH-1:0]  reg_data_t;

   localparam reg_addr_t ZERO_REG = '0;

   // One-hot register mask for the default register count; x0 maps to bit 0 like any other.
   function automatic logic [DEF_REG_NUM-1:0] onehot_dec(input reg_addr_t addr);
      logic [DEF_REG_NUM-1:0] mask;
      mask = '0;
      for (int r = 0; r < DEF_REG_NUM; r++) begin
         if (addr == reg_addr_t'(r)) mask[r] = 1'b1;
      end
      return mask;
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Issue/read/writeback bundle between decode-issue, writeback and the register file.
// Latency: n/a (wiring only).
// Backpressure: issue_ready is the only backpressure; writebacks are never refused.
interface regfile_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_NUM_BIT = 5,
   parameter int RD_PORTS    = 2,
   parameter int WR_PORTS    = 1
);
   logic [RD_PORTS*REG_NUM_BIT-1:0] raddr;
   logic [RD_PORTS-1:0]             ren;
   logic [RD_PORTS*DATA_WIDTH-1:0]  rdata;
   logic                            issue_valid;
   logic                            issue_ready;
   logic                            issue_wen;
   logic [REG_NUM_BIT-1:0]          issue_rd;
   logic [WR_PORTS-1:0]             wb_valid;
   logic [WR_PORTS*REG_NUM_BIT-1:0] wb_addr;
   logic [WR_PORTS*DATA_WIDTH-1:0]  wb_data;
   logic                            flush;
   logic [REG_NUM_BIT:0]            busy_cnt;

   // Pipeline side: decode/issue plus writeback.
   modport master (
      output raddr, ren, issue_valid, issue_wen, issue_rd,
             wb_valid, wb_addr, wb_data, flush,
      input  rdata, issue_ready, busy_cnt
   );

   // Register file side.
   modport slave (
      input  raddr, ren, issue_valid, issue_wen, issue_rd,
             wb_valid, wb_addr, wb_data, flush,
      output rdata, issue_ready, busy_cnt
   );
endinterface

// File: rtl/regfile_bypass_mux.sv
// Per-address writeback bypass: selects same-cycle writeback data over the stored value; x0 reads 0.
// Latency: combinational.
// Backpressure: none; wb_hit tells the scoreboard a busy register is being resolved this cycle.
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int REG_NUM     = 32,
   parameter int REG_NUM_BIT = 5,
   parameter int WR_PORTS    = 1
) (
   input  logic [REG_NUM_BIT-1:0]          raddr,
   input  logic [DATA_WIDTH-1:0]           rf_val,
   input  logic [WR_PORTS-1:0]             wb_valid,
   input  logic [WR_PORTS*REG_NUM_BIT-1:0] wb_addr,
   input  logic [WR_PORTS*DATA_WIDTH-1:0]  wb_data,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            wb_hit
);

   logic                  in_range;
   logic [DATA_WIDTH-1:0] byp_dat;

   assign in_range = ({1'b0, raddr} < (REG_NUM_BIT+1)'(REG_NUM));

   // Scan ports in ascending order so the highest-index matching port overrides lower ones.
   always_comb begin
      wb_hit  = 1'b0;
      byp_dat = '0;
      for (int p = 0; p < WR_PORTS; p++) begin
         if (wb_valid[p] && in_range && (wb_addr[p*REG_NUM_BIT +: REG_NUM_BIT] == raddr)) begin
            wb_hit  = 1'b1;
            byp_dat = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // x0 always reads zero, even if a writeback targets it this cycle.
   always_comb begin
      rdata = rf_val;
      if (raddr == REG_NUM_BIT'(ZERO_REG)) rdata = '0;
      else if (wb_hit)                     rdata = byp_dat;
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register busy scoreboard and writeback bypass; RF_TRACE_EN adds a sim trace.
// Latency: reads and issue_ready combinational; writes, busy bits and busy_cnt update on the next posedge.
// Backpressure: issue_ready drops on RAW/WAW hazard against an unresolved busy register, or during flush.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int REG_NUM     = DEF_REG_NUM,
   parameter int REG_NUM_BIT = DEF_REG_NUM_BIT,
   parameter int RD_PORTS    = DEF_RD_PORTS,
   parameter int WR_PORTS    = DEF_WR_PORTS
) (
   input logic     clk,
   input logic     rst,
   regfile_if.slave bus
);

   logic [DATA_WIDTH-1:0]  rf [REG_NUM];
   logic [REG_NUM-1:0]     busy;
   logic [REG_NUM_BIT:0]   busy_cnt_q;

   logic [DATA_WIDTH-1:0]  rf_rd   [RD_PORTS];
   logic [DATA_WIDTH-1:0]  rd_dat  [RD_PORTS];
   logic [RD_PORTS-1:0]    rd_hit;
   logic [RD_PORTS-1:0]    rd_busy;

   logic                   dst_hit;
   logic                   dst_busy;
   logic [DATA_WIDTH-1:0]  dst_unused_dat;

   logic                   src_haz;
   logic                   dst_haz;
   logic                   fire;
   logic [REG_NUM-1:0]     set_mask;
   logic [REG_NUM-1:0]     clr_mask;
   logic [REG_NUM-1:0]     busy_next;
   logic                   inc;
   logic [REG_NUM_BIT:0]   dec_cnt;
   logic [REG_NUM_BIT:0]   cnt_next;

   // Stored value and busy bit per read port; out-of-range addresses read as 0 and never busy.
   always_comb begin
      for (int i = 0; i < RD_PORTS; i++) begin
         rf_rd[i]   = '0;
         rd_busy[i] = 1'b0;
         for (int r = 0; r < REG_NUM; r++) begin
            if (bus.raddr[i*REG_NUM_BIT +: REG_NUM_BIT] == REG_NUM_BIT'(r)) begin
               rf_rd[i]   = rf[r];
               rd_busy[i] = busy[r];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
         regfile_bypass_mux #(
            .DATA_WIDTH  (DATA_WIDTH),
            .REG_NUM     (REG_NUM),
            .REG_NUM_BIT (REG_NUM_BIT),
            .WR_PORTS    (WR_PORTS)
         ) u_mux (
            .raddr    (bus.raddr[gi*REG_NUM_BIT +: REG_NUM_BIT]),
            .rf_val   (rf_rd[gi]),
            .wb_valid (bus.wb_valid),
            .wb_addr  (bus.wb_addr),
            .wb_data  (bus.wb_data),
            .rdata    (rd_dat[gi]),
            .wb_hit   (rd_hit[gi])
         );
      end
   endgenerate

   // Same bypass logic tells whether the destination's pending write lands this cycle.
   regfile_bypass_mux #(
      .DATA_WIDTH  (DATA_WIDTH),
      .REG_NUM     (REG_NUM),
      .REG_NUM_BIT (REG_NUM_BIT),
      .WR_PORTS    (WR_PORTS)
   ) u_dst_mux (
      .raddr    (bus.issue_rd),
      .rf_val   ('0),
      .wb_valid (bus.wb_valid),
      .wb_addr  (bus.wb_addr),
      .wb_data  (bus.wb_data),
      .rdata    (dst_unused_dat),
      .wb_hit   (dst_hit)
   );

   // Pack per-port read data onto the bus.
   always_comb begin
      bus.rdata = '0;
      for (int i = 0; i < RD_PORTS; i++) begin
         bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] = rd_dat[i];
      end
   end

   // Hazard detection and issue handshake.
   always_comb begin
      src_haz  = 1'b0;
      dst_busy = 1'b0;
      for (int i = 0; i < RD_PORTS; i++) begin
         if (bus.ren[i] && (bus.raddr[i*REG_NUM_BIT +: REG_NUM_BIT] != REG_NUM_BIT'(ZERO_REG)) &&
             rd_busy[i] && !rd_hit[i]) begin
            src_haz = 1'b1;
         end
      end
      for (int r = 0; r < REG_NUM; r++) begin
         if (bus.issue_rd == REG_NUM_BIT'(r)) dst_busy = busy[r];
      end
      dst_haz = bus.issue_wen && (bus.issue_rd != REG_NUM_BIT'(ZERO_REG)) && dst_busy && !dst_hit;
      bus.issue_ready = !src_haz && !dst_haz && !bus.flush;
      fire = bus.issue_valid && bus.issue_ready;
   end

   // Set/clear masks; starting at r=1 keeps x0 out of the scoreboard and drops out-of-range addresses.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      for (int r = 1; r < REG_NUM; r++) begin
         set_mask[r] = fire && bus.issue_wen && (bus.issue_rd == REG_NUM_BIT'(r));
         for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.wb_valid[p] && (bus.wb_addr[p*REG_NUM_BIT +: REG_NUM_BIT] == REG_NUM_BIT'(r))) begin
               clr_mask[r] = 1'b1;
            end
         end
      end
   end

   // Next busy vector and incremental count: set wins over clear, flush wins over everything.
   always_comb begin
      busy_next = (busy & ~clr_mask) | set_mask;
      inc       = |(set_mask & ~busy);
      dec_cnt   = '0;
      for (int r = 0; r < REG_NUM; r++) begin
         dec_cnt = dec_cnt + {{REG_NUM_BIT{1'b0}}, busy[r] & clr_mask[r] & ~set_mask[r]};
      end
      cnt_next = busy_cnt_q + {{REG_NUM_BIT{1'b0}}, inc} - dec_cnt;
      if (bus.flush) begin
         busy_next = '0;
         cnt_next  = '0;
      end
   end

   // Register array write; later (higher-index) ports override earlier ones on the same address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < REG_NUM; r++) rf[r] <= '0;
      end else begin
         for (int p = 0; p < WR_PORTS; p++) begin
            for (int r = 1; r < REG_NUM; r++) begin
               if (bus.wb_valid[p] && (bus.wb_addr[p*REG_NUM_BIT +: REG_NUM_BIT] == REG_NUM_BIT'(r))) begin
                  rf[r] <= bus.wb_data[p*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   // Scoreboard state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy       <= '0;
         busy_cnt_q <= '0;
      end else begin
         busy       <= busy_next;
         busy_cnt_q <= cnt_next;
      end
   end

   assign bus.busy_cnt = busy_cnt_q;

`ifdef RF_TRACE_EN
   // Simulation trace of writebacks, issue fires and flushes.
   always @(posedge clk) begin
      if (!rst) begin
         for (int p = 0; p < WR_PORTS; p++) begin
            if (bus.wb_valid[p]) begin
               $display("wb p=%0d addr=%0d data=%h", p,
                        bus.wb_addr[p*REG_NUM_BIT +: REG_NUM_BIT],
                        bus.wb_data[p*DATA_WIDTH +: DATA_WIDTH]);
            end
         end
         if (fire)      $display("issue rd=%0d", bus.issue_rd);
         if (bus.flush) $display("flush");
         if ((|bus.wb_valid) || fire || bus.flush) $display("busy_cnt=%0d", busy_cnt_q);
      end
   end
`else
   // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with two read and two writeback ports.
// Latency: checks combinational outputs mid-cycle and busy_cnt just after each posedge.
// Backpressure: issue_ready expectations cover RAW, WAW, bypass release and flush.
module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int RN = 32;
   localparam int AW = 5;
   localparam int RP = 2;
   localparam int WP = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   regfile_if #(.DATA_WIDTH(DW), .REG_NUM_BIT(AW), .RD_PORTS(RP), .WR_PORTS(WP)) bus ();

   regfile_scoreboard #(
      .DATA_WIDTH(DW), .REG_NUM(RN), .REG_NUM_BIT(AW), .RD_PORTS(RP), .WR_PORTS(WP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [AW-1:0] ra0, ra1;
      logic [1:0]    ren;
      logic          iv, iw;
      logic [AW-1:0] rd;
      logic [1:0]    wv;
      logic [AW-1:0] wa0;
      logic [DW-1:0] wd0;
      logic [AW-1:0] wa1;
      logic [DW-1:0] wd1;
      logic          fl;
      logic          e_rdy;
      logic [DW-1:0] e_rd0, e_rd1;
      logic [AW:0]   e_cnt;
   } vec_t;

   vec_t vecs[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input int ra0, input int ra1, input int ren, input int iv, input int iw,
                      input int rd, input int wv, input int wa0, input logic [31:0] wd0,
                      input int wa1, input logic [31:0] wd1, input int fl,
                      input int rdy, input logic [31:0] e0, input logic [31:0] e1, input int cnt);
      vec_t v;
      v.ra0 = AW'(ra0);  v.ra1 = AW'(ra1); v.ren = 2'(ren);
      v.iv  = 1'(iv);    v.iw  = 1'(iw);   v.rd  = AW'(rd);
      v.wv  = 2'(wv);    v.wa0 = AW'(wa0); v.wd0 = wd0;
      v.wa1 = AW'(wa1);  v.wd1 = wd1;      v.fl  = 1'(fl);
      v.e_rdy = 1'(rdy); v.e_rd0 = e0;     v.e_rd1 = e1; v.e_cnt = (AW+1)'(cnt);
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.raddr       = {v.ra1, v.ra0};
      bus.ren         = v.ren;
      bus.issue_valid = v.iv;
      bus.issue_wen   = v.iw;
      bus.issue_rd    = v.rd;
      bus.wb_valid    = v.wv;
      bus.wb_addr     = {v.wa1, v.wa0};
      bus.wb_data     = {v.wd1, v.wd0};
      bus.flush       = v.fl;
   endtask

   task automatic idle();
      bus.raddr = '0; bus.ren = '0; bus.issue_valid = 1'b0; bus.issue_wen = 1'b0;
      bus.issue_rd = '0; bus.wb_valid = '0; bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      #2;
      check("reset busy_cnt", 32'(bus.busy_cnt), 32'd0);
      check("reset issue_ready", 32'(bus.issue_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;

      //   ra0 ra1 ren iv iw rd  wv wa0 wd0           wa1 wd1           fl  rdy rd0           rd1           cnt
      add( 0,  0,  1, 0, 0, 0,  1, 0, 32'hDEADBEEF, 0, 32'h0,        0,  1, 32'h0,        32'h0,        0); // wb to x0
      add( 0,  0,  1, 1, 1, 0,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        0); // x0 dest never busy
      add( 0,  0,  0, 1, 1, 5,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        1); // issue rd=5
      add( 5,  0,  1, 1, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0,        1); // RAW stall
      add( 5,  0,  1, 1, 0, 0,  1, 5, 32'h12345678, 0, 32'h0,        0,  1, 32'h12345678, 32'h0,        0); // bypass release
      add( 5,  9,  0, 1, 1, 7,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h12345678, 32'h0,        1); // issue rd=7
      add( 7,  0,  0, 1, 1, 7,  1, 7, 32'hAAAA0007, 0, 32'h0,        0,  1, 32'hAAAA0007, 32'h0,        1); // WAW resolved, set wins
      add( 7,  0,  0, 1, 1, 7,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'hAAAA0007, 32'h0,        1); // WAW stall
      add( 9,  7,  0, 0, 0, 0,  3, 9, 32'h1,        9, 32'h2,        0,  1, 32'h2,        32'hAAAA0007, 1); // dual wb same addr
      add( 9,  7,  2, 0, 0, 0,  2, 0, 32'h0,        7, 32'hBBBB0007, 0,  1, 32'h2,        32'hBBBB0007, 0); // port1 clears rd=7
      add( 9,  0,  0, 1, 1, 3,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h2,        32'h0,        1);
      add( 0,  0,  0, 1, 1, 4,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        2);
      add( 0,  0,  0, 1, 1, 6,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        3);
      add( 5,  9,  0, 1, 1, 8,  1,10, 32'hCAFE000A, 0, 32'h0,        1,  0, 32'h12345678, 32'h2,        0); // flush
      add(10,  3,  2, 0, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'hCAFE000A, 32'h0,        0); // busy gone, data kept
      add( 3,  0,  1, 1, 1, 3,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        1);
      add( 0,  0,  0, 1, 1, 4,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        2);
      add( 0,  0,  0, 1, 1, 6,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        3);
      add( 0,  0,  0, 0, 1, 9,  0, 0, 32'h0,        0, 32'h0,        0,  1, 32'h0,        32'h0,        3); // no valid, no set
      add( 0,  4,  2, 1, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0,        3); // RAW on port 1

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d issue_ready", i), 32'(bus.issue_ready), 32'(vecs[i].e_rdy));
         check($sformatf("v%0d rdata0", i), bus.rdata[31:0], vecs[i].e_rd0);
         check($sformatf("v%0d rdata1", i), bus.rdata[63:32], vecs[i].e_rd1);
         @(posedge clk);
         #1;
         check($sformatf("v%0d busy_cnt", i), 32'(bus.busy_cnt), 32'(vecs[i].e_cnt));
      end

      // Reset mid-run with three busy registers: effects are immediate.
      @(negedge clk);
      idle();
      rst = 1'b1;
      #1;
      check("midrst busy_cnt", 32'(bus.busy_cnt), 32'd0);
      check("midrst issue_ready", 32'(bus.issue_ready), 32'd1);
      for (int r = 1; r < RN; r++) begin
         bus.raddr = {AW'(0), AW'(r)};
         #1;
         check($sformatf("midrst rf[%0d]", r), bus.rdata[31:0], 32'h0);
      end
      bus.raddr = {AW'(0), AW'(4)};
      bus.ren   = 2'b01;
      #1;
      check("midrst no RAW on 4", 32'(bus.issue_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      idle();

      // Late writeback after reset still lands; busy stays clear.
      @(negedge clk);
      bus.wb_valid = 2'b01;
      bus.wb_addr  = {AW'(0), AW'(12)};
      bus.wb_data  = {32'h0, 32'h00000055};
      @(posedge clk);
      #1;
      check("postrst busy_cnt", 32'(bus.busy_cnt), 32'd0);
      @(negedge clk);
      idle();
      bus.raddr       = {AW'(0), AW'(12)};
      bus.ren         = 2'b01;
      bus.issue_valid = 1'b1;
      bus.issue_wen   = 1'b1;
      bus.issue_rd    = AW'(12);
      #1;
      check("postrst rf[12]", bus.rdata[31:0], 32'h00000055);
      check("postrst issue_ready", 32'(bus.issue_ready), 32'd1);
      @(posedge clk);
      #1;
      check("postrst issue busy_cnt", 32'(bus.busy_cnt), 32'd1);
      @(negedge clk);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
